// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 codes, FSM state encoding, timeout default and request legality check for load_store_unit
package lsu_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    typedef logic [2:0] lsu_state_t;
    localparam lsu_state_t S_IDLE   = 3'd0;
    localparam lsu_state_t S_RD     = 3'd1;
    localparam lsu_state_t S_RMW_RD = 3'd2;
    localparam lsu_state_t S_WR     = 3'd3;
    localparam lsu_state_t S_RESP   = 3'd4;
    localparam int TIMEOUT_DEFAULT = 256;
    // Unsupported width codes, unsigned stores, and misaligned half/word accesses are rejected
    function automatic logic bad_req(input logic we, input logic [2:0] f3, input logic [1:0] off);
        return f3 == 3'b011 || f3[2:1] == 2'b11 || (f3[2] && we) ||
               (f3[1:0] == F3_H[1:0] && off[0]) || (f3 == F3_W && off != 2'b00);
    endfunction
endpackage

// File: rtl/lsu_if.sv
// load_store_unit_if: word-addressed memory bus between load_store_unit (master) and Memory (slave)
//   rd_en/wr_en : access strobes, held until ack
//   addr/wdata  : word-aligned address and write data, stable while a strobe is high
//   rdata/ack   : read data and access acknowledge from Memory
interface load_store_unit_if;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;
    modport master (output rd_en, wr_en, addr, wdata, input rdata, ack);
    modport slave  (input rd_en, wr_en, addr, wdata, output rdata, ack);
endinterface

// File: rtl/lsu_align.sv
// lsu_align: little-endian lane extract/extend for loads and lane merge for sub-word stores
//   word  : memory word (load source / old word for merge)
//   wdata : store data, low byte/half used for SB/SH
//   off   : byte offset addr[1:0]
//   f3    : funct3 width/sign code
//   ld    : extracted and extended load result
//   st    : word to write back
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [1:0]  off,
    input  logic [2:0]  f3,
    output logic [31:0] ld,
    output logic [31:0] st
);
    logic [4:0]  sa;
    logic [31:0] sh;
    logic [31:0] mask;
    always_comb begin
        sa   = {off, 3'b000};
        sh   = word >> sa;
        ld   = f3[1:0] == F3_B[1:0] ? {{24{sh[7] & ~f3[2]}}, sh[7:0]} :
               f3[1:0] == F3_H[1:0] ? {{16{sh[15] & ~f3[2]}}, sh[15:0]} : word;
        mask = (f3[1:0] == F3_B[1:0] ? 32'h0000_00FF : 32'h0000_FFFF) << sa;
        st   = f3[1:0] == F3_W[1:0] ? wdata : (word & ~mask) | ((wdata << sa) & mask);
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: turns RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW into word-aligned memory accesses
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        done_o,
  output logic        err_o,
  output logic        busy_o,
  output logic        mem_rd_en_o,
  output logic        mem_wr_en_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i
);
  lsu_state_t  state;
  logic        err;
  logic [2:0]  f3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [31:0] ld_word;
  logic [31:0] st_word;
  logic        bad;
  logic        tmo;
  lsu_align u_align (
    .word  (mem_rdata_i),
    .wdata (wdata),
    .off   (addr[1:0]),
    .f3    (f3),
    .ld    (ld_word),
    .st    (st_word)
  );
  assign bad         = bad_req(we_i, funct3_i, addr_i[1:0]);
  assign busy_o      = state != S_IDLE;
  assign done_o      = state == S_RESP;
  assign err_o       = done_o && err;
  assign rdata_o     = rdata;
  assign mem_rd_en_o = state == S_RD || state == S_RMW_RD;
  assign mem_wr_en_o = state == S_WR;
  assign mem_addr_o  = {addr[31:2], 2'b00};
  assign mem_wdata_o = wdata;
`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  assign tmo = (mem_rd_en_o || mem_wr_en_o) && cnt == CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk)
    cnt <= (!rst_n || !(mem_rd_en_o || mem_wr_en_o) || mem_ack_i || tmo) ? '0 : cnt + 1'b1;
`else
  assign tmo = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      err   <= 1'b0;
      f3    <= '0;
      addr  <= '0;
      wdata <= '0;
      rdata <= '0;
    end else begin
      case (state)
        S_IDLE: if (req_i) begin
          f3    <= funct3_i;
          addr  <= addr_i;
          wdata <= wdata_i;
          err   <= bad;
          if (bad) rdata <= '0;
          state <= bad ? S_RESP : !we_i ? S_RD : funct3_i == F3_W ? S_WR : S_RMW_RD;
        end
        S_RESP: state <= S_IDLE;
        default: if (mem_ack_i) begin
          if (state == S_RD) rdata <= ld_word;
          if (state == S_RMW_RD) wdata <= st_word;
          state <= state == S_RMW_RD ? S_WR : S_RESP;
        end else if (tmo) begin
          err   <= 1'b1;
          state <= S_RESP;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and randomized checks of load_store_unit against a byte-level reference model
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  f3 = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        done;
  logic        err;
  logic        busy;
  logic        mem_rd_en;
  logic        mem_wr_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        ack_r = 1'b0;
  logic        stall = 1'b0;
  int          ack_delay = 0;
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  int          dones = 0, rd_cyc = 0, wr_cyc = 0, rd_cnt = 0, wr_cnt = 0, both_hi = 0, unstable = 0;
  logic        prev_en = 1'b0;
  logic [31:0] prev_addr = '0, prev_wdata = '0;
  logic [31:0] sram [128];
  logic [31:0] refm [128];
  logic [31:0] exp_rdata = '0;
  assign mem_rdata = sram[mem_addr[8:2]];
  load_store_unit #(.TIMEOUT_CYCLES(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req),
    .we_i        (we),
    .funct3_i    (f3),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .rdata_o     (rdata),
    .done_o      (done),
    .err_o       (err),
    .busy_o      (busy),
    .mem_rd_en_o (mem_rd_en),
    .mem_wr_en_o (mem_wr_en),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata),
    .mem_ack_i   (ack_r)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    logic en;
    en = mem_rd_en || mem_wr_en;
    if (mem_rd_en && mem_wr_en) both_hi++;
    if (done) dones++;
    if (mem_rd_en) rd_cyc++;
    if (mem_wr_en) wr_cyc++;
    if (en && prev_en && !ack_r && (mem_addr !== prev_addr || mem_wdata !== prev_wdata)) unstable++;
    prev_en    = en;
    prev_addr  = mem_addr;
    prev_wdata = mem_wdata;
    cyc   = !en ? 0 : ack_r ? 1 : cyc + 1;
    ack_r = en && !stall && cyc == ack_delay + 1;
    if (ack_r && mem_wr_en) begin
      sram[mem_addr[8:2]] = mem_wdata;
      wr_cnt++;
    end
    if (ack_r && mem_rd_en) rd_cnt++;
  end
  function automatic logic ref_bad(input logic w, input int f, input int off);
    if (!(f == 0 || f == 1 || f == 2 || f == 4 || f == 5)) return 1'b1;
    if (w && f >= 4) return 1'b1;
    if ((f == 1 || f == 5) && off % 2 != 0) return 1'b1;
    if (f == 2 && off != 0) return 1'b1;
    return 1'b0;
  endfunction
  function automatic int nbytes(input int f);
    return (f % 4 == 0) ? 1 : (f % 4 == 1) ? 2 : 4;
  endfunction
  function automatic logic [31:0] ref_load(input logic [31:0] w, input int off, input int f);
    longint v = 0;
    int n = nbytes(f);
    for (int k = 0; k < n; k++) v += longint'((w >> (8 * (off + k))) & 32'hFF) << (8 * k);
    if (f < 4 && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
    return v[31:0];
  endfunction
  function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [31:0] d, input int off, input int f);
    logic [7:0] b [4];
    logic [31:0] r = '0;
    for (int k = 0; k < 4; k++) b[k] = 8'(w >> (8 * k));
    for (int k = 0; k < nbytes(f); k++) b[off + k] = 8'(d >> (8 * k));
    for (int k = 0; k < 4; k++) r |= 32'(b[k]) << (8 * k);
    return r;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask
  task automatic issue(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    we = w; f3 = f; addr = a; wdata = d; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
  endtask
  task automatic wait_done(output logic ok, output logic e, output logic [31:0] r);
    ok = 1'b0; e = 1'b0; r = '0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (done) begin
        ok = 1'b1; e = err; r = rdata;
      end else @(negedge clk);
    end
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    logic [31:0] la [4] = '{32'h101, 32'h103, 32'h103, 32'h102};
    logic [2:0]  lf [4] = '{3'd0, 3'd0, 3'd4, 3'd1};
    logic [31:0] lx [4] = '{32'h0000007F, 32'hFFFFFF81, 32'h00000081, 32'hFFFF8180};
    logic        ok, e, w, e_exp;
    logic [2:0]  f;
    logic [31:0] r, a, d;
    int          r0, w0, d0, i0;
    for (int i = 0; i < 128; i++) begin
      sram[i] = $urandom;
      refm[i] = sram[i];
    end
    sram[64] = 32'h81807F01;
    refm[64] = 32'h81807F01;
    repeat (2) @(negedge clk);
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_addr", mem_addr, 32'h0);
    chk("reset_wdata", mem_wdata, 32'h0);
    chk("reset_flags", {27'd0, done, err, busy, mem_rd_en, mem_wr_en}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      d0 = dones;
      issue(1'b0, lf[i], la[i], 32'h0);
      wait_done(ok, e, r);
      chk("load_done", {31'd0, ok}, 32'd1);
      chk("load_err", {31'd0, e}, 32'd0);
      chk("load_rdata", r, lx[i]);
      @(negedge clk);
      chk("load_one_pulse", 32'(dones - d0), 32'd1);
    end
    exp_rdata = 32'hFFFF8180;
    ack_delay = 5;
    r0 = rd_cyc; w0 = wr_cyc;
    issue(1'b0, 3'd2, 32'h100, 32'h0);
    req = 1'b1; we = 1'b1; f3 = 3'd2; addr = 32'h200; wdata = 32'hDEADBEEF;
    repeat (3) @(negedge clk);
    req = 1'b0;
    wait_done(ok, e, r);
    chk("lw_slow_done", {31'd0, ok}, 32'd1);
    chk("lw_slow_err", {31'd0, e}, 32'd0);
    chk("lw_slow_rdata", r, 32'h81807F01);
    chk("lw_slow_rd_cycles", 32'(rd_cyc - r0), 32'd6);
    exp_rdata = 32'h81807F01;
    @(negedge clk);
    chk("lw_slow_idle", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    chk("lw_slow_req_ignored", 32'(wr_cyc - w0), 32'd0);
    ack_delay = 0;
    r0 = rd_cnt; w0 = wr_cnt;
    issue(1'b1, 3'd0, 32'h102, 32'h123456AB);
    wait_done(ok, e, r);
    chk("sb_done", {31'd0, ok}, 32'd1);
    chk("sb_err", {31'd0, e}, 32'd0);
    chk("sb_word", sram[64], 32'h81AB7F01);
    chk("sb_accesses", {16'(rd_cnt - r0), 16'(wr_cnt - w0)}, {16'd1, 16'd1});
    refm[64] = 32'h81AB7F01;
    @(negedge clk);
    r0 = rd_cyc; w0 = wr_cyc;
    issue(1'b1, 3'd2, 32'h102, 32'hCAFEF00D);
    chk("sw_mis_done", {31'd0, done}, 32'd1);
    chk("sw_mis_err", {31'd0, err}, 32'd1);
    chk("sw_mis_rdata", rdata, 32'h0);
    exp_rdata = '0;
    @(negedge clk);
    chk("sw_mis_no_access", {16'(rd_cyc - r0), 16'(wr_cyc - w0)}, 32'h0);
    for (int n = 0; n < 40; n++) begin
      w = 1'($urandom_range(0, 1));
      f = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 127) << 2) | $urandom_range(0, 3);
      d = $urandom;
      i0 = int'(a[8:2]);
      ack_delay = $urandom_range(0, 3);
      e_exp = ref_bad(w, int'(f), int'(a[1:0]));
      r0 = rd_cnt; w0 = wr_cnt;
      issue(w, f, a, d);
      wait_done(ok, e, r);
      chk("rnd_done", {31'd0, ok}, 32'd1);
      chk("rnd_err", {31'd0, e}, {31'd0, e_exp});
      if (e_exp) begin
        exp_rdata = '0;
        chk("rnd_no_access", 32'(rd_cnt - r0 + wr_cnt - w0), 32'd0);
      end else if (!w) begin
        exp_rdata = ref_load(refm[i0], int'(a[1:0]), int'(f));
      end else begin
        refm[i0] = ref_store(refm[i0], d, int'(a[1:0]), int'(f));
        chk("rnd_mem", sram[i0], refm[i0]);
      end
      chk("rnd_rdata", r, exp_rdata);
      @(negedge clk);
    end
    ack_delay = 0;
`ifdef LSU_TIMEOUT_EN
    stall = 1'b1;
    r0 = rd_cyc;
    issue(1'b0, 3'd2, 32'h100, 32'h0);
    wait_done(ok, e, r);
    chk("tmo_done", {31'd0, ok}, 32'd1);
    chk("tmo_err", {31'd0, e}, 32'd1);
    chk("tmo_rdata", r, exp_rdata);
    chk("tmo_rd_cycles", 32'(rd_cyc - r0), 32'd8);
    @(negedge clk);
    chk("tmo_enables", {30'd0, mem_rd_en, mem_wr_en}, 32'd0);
    stall = 1'b0;
`endif
    w0 = wr_cnt; d0 = dones;
    stall = 1'b1;
    issue(1'b1, 3'd1, 32'h104, 32'h5555AAAA);
    @(negedge clk);
    chk("rst_in_rmw_rd", {30'd0, mem_rd_en, mem_wr_en}, 32'd2);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_flags", {27'd0, done, err, busy, mem_rd_en, mem_wr_en}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    rst_n = 1'b1;
    stall = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_no_write_no_done", {16'(wr_cnt - w0), 16'(dones - d0)}, 32'h0);
    chk("never_both_enables", 32'(both_hi), 32'd0);
    chk("bus_stable", 32'(unstable), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
